// File: rtl/rl_lj_pair_scheduler.sv
// rtl/rl_lj_pair_scheduler.sv - multi-lane (reference, neighbor) pair sweep with BRAM-aligned valids
module rl_lj_pair_scheduler #(
  parameter int NUM_PIPELINES           = 1,
  parameter int REF_PARTICLE_NUM        = 10,
  parameter int REF_RAM_ADDR_WIDTH      = 4,
  parameter int NEIGHBOR_PARTICLE_NUM   = 10,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 4,
  parameter int RAM_READ_LATENCY        = 2,
  parameter int SKIP_SELF               = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              pipe_ready,
  output logic [REF_RAM_ADDR_WIDTH-1:0]                     ref_addr,
  output logic [NUM_PIPELINES*NEIGHBOR_RAM_ADDR_WIDTH-1:0]  neighbor_addr,
  output logic [NUM_PIPELINES-1:0]                          pair_valid,
  output logic                                              ref_last,
  output logic                                              busy,
  output logic                                              done
);

  localparam int RW = REF_RAM_ADDR_WIDTH;
  localparam int NW = NEIGHBOR_RAM_ADDR_WIDTH;
  localparam int L  = RAM_READ_LATENCY;
  localparam int DW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;

  state_t                         state, state_next;
  logic                           start_q;
  logic [RW:0]                    r_cnt;
  logic [NW:0]                    n_base;
  logic [DW-1:0]                  drain_cnt;
  logic [L-1:0][NUM_PIPELINES-1:0] valid_line;
  logic [L-1:0]                   last_line;

  logic                           start_rise, issue, wrap, last_ref;
  logic [NUM_PIPELINES-1:0]       raw_valid;
  logic [31:0]                    lane_n [NUM_PIPELINES];

  assign start_rise = start & ~start_q;
  assign issue      = (state == RUN) & pipe_ready;
  assign wrap       = (32'(n_base) + 32'(NUM_PIPELINES)) >= 32'(NEIGHBOR_PARTICLE_NUM);
  assign last_ref   = 32'(r_cnt) == 32'(REF_PARTICLE_NUM - 1);

  // Lanes beyond the neighbor list stay invalid and park their address at 0.
  always_comb begin
    raw_valid     = '0;
    neighbor_addr = '0;
    ref_addr      = (state == RUN) ? r_cnt[RW-1:0] : '0;
    for (int k = 0; k < NUM_PIPELINES; k++) begin
      lane_n[k] = 32'(n_base) + 32'(k);
      if (lane_n[k] < 32'(NEIGHBOR_PARTICLE_NUM)) begin
        raw_valid[k] = issue & !((SKIP_SELF != 0) && (32'(r_cnt) == lane_n[k]));
        if (state == RUN) neighbor_addr[k*NW +: NW] = lane_n[k][NW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_rise) state_next = RUN;
      RUN:     if (issue && wrap && last_ref) state_next = DRAIN;
      DRAIN:   if (32'(drain_cnt) == 32'(L - 1)) state_next = DONE_S;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE_S);
  assign pair_valid = valid_line[L-1];
  assign ref_last   = last_line[L-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      r_cnt      <= '0;
      n_base     <= '0;
      drain_cnt  <= '0;
      valid_line <= '0;
      last_line  <= '0;
    end else begin
      state   <= state_next;
      start_q <= start;
      if (state == IDLE && start_rise) begin
        r_cnt  <= '0;
        n_base <= '0;
      end else if (issue) begin
        if (wrap) begin
          n_base <= '0;
          r_cnt  <= r_cnt + 1'b1;
        end else begin
          n_base <= n_base + (NW+1)'(NUM_PIPELINES);
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      // Delay line keeps moving while stalled so valids stay locked to BRAM latency.
      valid_line[0] <= raw_valid;
      last_line[0]  <= issue & wrap;
      for (int i = 1; i < L; i++) begin
        valid_line[i] <= valid_line[i-1];
        last_line[i]  <= last_line[i-1];
      end
    end
  end

endmodule
